// File: rtl/tc_io_gpio_bank.sv
// Bank of NCH general-purpose I/O channels. Each channel drives a tri-state pad
// from direction/output flops and samples the pad through a 2-flop synchroniser,
// a debounce filter and a rise/fall detector feeding sticky interrupt-pending
// bits. A valid/ready register port gives the SoC bus access to the bank.
module tc_io_gpio_bank #(
  parameter int NCH    = 8,
  parameter int DB_CYC = 4
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           reg_valid_i,
  input  logic           reg_we_i,
  input  logic [2:0]     reg_addr_i,
  input  logic [31:0]    reg_wdata_i,
  output logic [31:0]    reg_rdata_o,
  output logic           reg_ready_o,
  output logic [NCH-1:0] pad_c2p_o,
  output logic [NCH-1:0] pad_c2p_en_o,
  input  logic [NCH-1:0] pad_p2c_i,
  output logic           irq_o
);

  localparam int              CW       = $clog2(DB_CYC + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYC - 1);

  localparam logic [2:0] ADDR_DIR     = 3'd0;
  localparam logic [2:0] ADDR_OUT     = 3'd1;
  localparam logic [2:0] ADDR_IN      = 3'd2;
  localparam logic [2:0] ADDR_RISE_IE = 3'd3;
  localparam logic [2:0] ADDR_FALL_IE = 3'd4;
  localparam logic [2:0] ADDR_IP      = 3'd5;
  localparam logic [2:0] ADDR_RAW     = 3'd6;

  logic [NCH-1:0] dir_q, out_q, rise_ie_q, fall_ie_q, ip_q;
  logic [NCH-1:0] s1_q, s2_q, stable_q, stable_dly_q;
  logic [CW-1:0]  cnt_q [NCH];
  logic           ready_q;
  logic [31:0]    rdata_q;

  logic           acc, wr;
  logic [NCH-1:0] wdata_ch, rise, fall, ip_set, ip_clr;
  logic [31:0]    rd_val;
  logic           unused_wdata;

  // An access is taken only when no completion pulse is pending, which
  // spaces back-to-back requests two cycles apart.
  assign acc      = reg_valid_i & ~ready_q;
  assign wr       = acc & reg_we_i;
  assign wdata_ch = reg_wdata_i[NCH-1:0];
  // Bits above the channel count are architecturally ignored.
  assign unused_wdata = ^reg_wdata_i;

  assign rise   = stable_q & ~stable_dly_q;
  assign fall   = ~stable_q & stable_dly_q;
  assign ip_set = (rise & rise_ie_q) | (fall & fall_ie_q);
  assign ip_clr = (wr && reg_addr_i == ADDR_IP) ? wdata_ch : '0;

  // Read mux over the pre-edge register values; unmapped bits read 0.
  always_comb begin
    // NOTE: every path assigns rd_val, starting from this default, so no latch is inferred.
    rd_val = '0;
    case (reg_addr_i)
      ADDR_DIR:     rd_val[NCH-1:0] = dir_q;
      ADDR_OUT:     rd_val[NCH-1:0] = out_q;
      ADDR_IN:      rd_val[NCH-1:0] = stable_q;
      ADDR_RISE_IE: rd_val[NCH-1:0] = rise_ie_q;
      ADDR_FALL_IE: rd_val[NCH-1:0] = fall_ie_q;
      ADDR_IP:      rd_val[NCH-1:0] = ip_q;
      ADDR_RAW:     rd_val[NCH-1:0] = s2_q;
      default:      rd_val = '0;
    endcase
  end

  // Control registers and sticky pending bits; a new edge beats a W1C clear.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      dir_q     <= '0;
      out_q     <= '0;
      rise_ie_q <= '0;
      fall_ie_q <= '0;
      ip_q      <= '0;
    end else begin
      if (wr) begin
        case (reg_addr_i)
          ADDR_DIR:     dir_q     <= wdata_ch;
          ADDR_OUT:     out_q     <= wdata_ch;
          ADDR_RISE_IE: rise_ie_q <= wdata_ch;
          ADDR_FALL_IE: fall_ie_q <= wdata_ch;
          default:      ;
        endcase
      end
      ip_q <= (ip_q & ~ip_clr) | ip_set;
    end
  end

  // Completion pulse and read data, registered one cycle after acceptance.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= acc;
      rdata_q <= (acc && !reg_we_i) ? rd_val : '0;
    end
  end

  // Two-flop synchroniser for the asynchronous pad inputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= pad_p2c_i;
      s2_q <= s1_q;
    end
  end

  // Debounce: accept a new level only after it differs for DB_CYC cycles.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stable_q     <= '0;
      stable_dly_q <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it takes reset like any register.
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      stable_dly_q <= stable_q;
      for (int i = 0; i < NCH; i++) begin
        if (s2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_q[i] <= s2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign pad_c2p_en_o = dir_q;
  assign pad_c2p_o    = out_q;
  assign reg_ready_o  = ready_q;
  assign reg_rdata_o  = rdata_q;
  assign irq_o        = |ip_q;

endmodule

// File: tb/tb_tc_io_gpio_bank.sv
// Self-checking bench for tc_io_gpio_bank: directed scenarios with literal
// expectations, then randomized bus traffic and pad activity, all compared
// every cycle against a behavioural model of the bank.
module tb_tc_io_gpio_bank;

  localparam int NCH    = 8;
  localparam int DB_CYC = 4;

  logic           clk, rst_n;
  logic           reg_valid, reg_we, reg_ready;
  logic [2:0]     reg_addr;
  logic [31:0]    reg_wdata, reg_rdata;
  logic [NCH-1:0] pad_c2p, pad_c2p_en, pad_p2c, pad_ext;
  logic           irq;
  logic           chk_en;

  int checks   = 0;
  int failures = 0;

  tc_io_gpio_bank #(.NCH(NCH), .DB_CYC(DB_CYC)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .reg_valid_i  (reg_valid),
    .reg_we_i     (reg_we),
    .reg_addr_i   (reg_addr),
    .reg_wdata_i  (reg_wdata),
    .reg_rdata_o  (reg_rdata),
    .reg_ready_o  (reg_ready),
    .pad_c2p_o    (pad_c2p),
    .pad_c2p_en_o (pad_c2p_en),
    .pad_p2c_i    (pad_p2c),
    .irq_o        (irq)
  );

  // Tri-state pad: a driven channel sees its own output, otherwise the board level.
  assign pad_p2c = (pad_c2p_en & pad_c2p) | (~pad_c2p_en & pad_ext);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NCH-1:0] m_dir, m_out, m_rie, m_fie, m_ip;
  logic [NCH-1:0] m_s1, m_s2, m_stable, m_prev;
  logic [NCH-1:0] m_hist [DB_CYC];   // last DB_CYC synchronised samples, [0] newest
  logic           m_ready;
  logic [31:0]    m_rdata;

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [NCH-1:0] v;
    case (a)
      3'd0: v = m_dir;
      3'd1: v = m_out;
      3'd2: v = m_stable;
      3'd3: v = m_rie;
      3'd4: v = m_fie;
      3'd5: v = m_ip;
      3'd6: v = m_s2;
      default: v = '0;
    endcase
    return 32'(v);
  endfunction

  task automatic model_step();
    logic [NCH-1:0] pad_now, set, clr, flip, wd;
    logic [31:0]    rv;
    logic           acc;
    if (!rst_n) begin
      {m_dir, m_out, m_rie, m_fie, m_ip} = '0;
      {m_s1, m_s2, m_stable, m_prev}     = '0;
      for (int j = 0; j < DB_CYC; j++) m_hist[j] = '0;
      m_ready = 1'b0;
      m_rdata = '0;
    end else begin
      pad_now = (m_dir & m_out) | (~m_dir & pad_ext);
      acc     = reg_valid && !m_ready;
      rv      = model_read(reg_addr);
      wd      = reg_wdata[NCH-1:0];
      // A level is new when stable just differs from its value one cycle earlier.
      set = (m_stable & ~m_prev & m_rie) | (~m_stable & m_prev & m_fie);
      // Window of recent samples: flip a channel once all DB_CYC disagree with it.
      for (int j = DB_CYC - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = m_s2;
      flip = '1;
      for (int j = 0; j < DB_CYC; j++) flip &= (m_hist[j] ^ m_stable);
      m_prev   = m_stable;
      m_stable = m_stable ^ flip;
      m_s2     = m_s1;
      m_s1     = pad_now;
      clr = '0;
      if (acc && reg_we) begin
        case (reg_addr)
          3'd0: m_dir = wd;
          3'd1: m_out = wd;
          3'd3: m_rie = wd;
          3'd4: m_fie = wd;
          3'd5: clr   = wd;
          default: ;
        endcase
      end
      m_ip    = (m_ip & ~clr) | set;
      m_rdata = (acc && !reg_we) ? rv : 32'd0;
      m_ready = acc;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Output comparison on every falling edge once reset has been applied.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cmp_ready",  32'(reg_ready),  32'(m_ready));
      check("cmp_rdata",  reg_rdata,       m_rdata);
      check("cmp_c2p",    32'(pad_c2p),    32'(m_out));
      check("cmp_c2p_en", 32'(pad_c2p_en), 32'(m_dir));
      check("cmp_irq",    32'(irq),        32'(|m_ip));
    end
  end

  // ---------------- bus helpers (start and end on a falling edge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus(input logic we, input logic [2:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd);
    int n;
    reg_valid = 1'b1;
    reg_we    = we;
    reg_addr  = addr;
    reg_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!reg_ready && n < 8);
    check("bus_ready", 32'(reg_ready), 32'd1);
    rd        = reg_rdata;
    reg_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    int          cnt;
    rst_n = 1'b0; reg_valid = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
    pad_ext = '0; chk_en = 1'b0;

    // Reset: outputs idle and every address reads 0.
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_c2p",    32'(pad_c2p),    32'd0);
    check("rst_c2p_en", 32'(pad_c2p_en), 32'd0);
    check("rst_irq",    32'(irq),        32'd0);
    check("rst_ready",  32'(reg_ready),  32'd0);
    check("rst_rdata",  reg_rdata,       32'd0);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus(1'b0, 3'(a), 32'd0, rd);
      check($sformatf("rst_read%0d", a), rd, 32'd0);
    end

    // Output drive: pads follow the written registers right after acceptance.
    bus(1'b1, 3'd0, 32'h0000_00F0, rd);
    bus(1'b1, 3'd1, 32'h0000_00A5, rd);
    check("drive_en",  32'(pad_c2p_en), 32'h0000_00F0);
    check("drive_out", 32'(pad_c2p),    32'h0000_00A5);
    bus(1'b0, 3'd1, 32'd0, rd);
    check("read_out", rd, 32'h0000_00A5);
    bus(1'b1, 3'd0, 32'hFFFF_FFFF, rd);
    bus(1'b0, 3'd0, 32'd0, rd);
    check("read_dir_masked", rd, 32'h0000_00FF);
    bus(1'b1, 3'd7, 32'hFFFF_FFFF, rd);
    bus(1'b0, 3'd7, 32'd0, rd);
    check("read_rsvd", rd, 32'd0);
    bus(1'b1, 3'd0, 32'd0, rd);
    idle(12);

    // Debounce: a 3-cycle glitch is filtered out.
    bus(1'b1, 3'd3, 32'h01, rd);
    pad_ext[0] = 1'b1;
    idle(3);
    pad_ext[0] = 1'b0;
    idle(12);
    bus(1'b0, 3'd2, 32'd0, rd);
    check("glitch_in", rd, 32'd0);
    bus(1'b0, 3'd5, 32'd0, rd);
    check("glitch_ip", rd, 32'd0);

    // Debounce: 10-cycle high; IN still 0 when read at s1-edge+5, irq 6 cycles after s1.
    pad_ext[0] = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      check($sformatf("db_irq_early%0d", n), 32'(irq), 32'd0);
    end
    reg_valid = 1'b1; reg_we = 1'b0; reg_addr = 3'd2;
    @(negedge clk);
    check("db_ready",     32'(reg_ready), 32'd1);
    check("db_in_before", reg_rdata,      32'd0);
    check("db_irq_n6",    32'(irq),       32'd0);
    reg_valid = 1'b0;
    @(negedge clk);
    check("db_irq_n7", 32'(irq), 32'd1);
    bus(1'b0, 3'd2, 32'd0, rd);
    check("db_in_after", rd, 32'h01);
    idle(2);
    pad_ext[0] = 1'b0;
    idle(12);
    bus(1'b1, 3'd5, 32'hFF, rd);
    check("db_w1c_irq", 32'(irq), 32'd0);

    // Edge interrupts with RISE_IE=0x01, FALL_IE=0x02.
    bus(1'b1, 3'd3, 32'h01, rd);
    bus(1'b1, 3'd4, 32'h02, rd);
    pad_ext[0] = 1'b1;
    idle(10);
    bus(1'b0, 3'd5, 32'd0, rd);
    check("edge_ip_rise0", rd, 32'h01);
    check("edge_irq_rise0", 32'(irq), 32'd1);
    pad_ext[1] = 1'b1;
    idle(10);
    bus(1'b0, 3'd5, 32'd0, rd);
    check("edge_ip_rise1", rd, 32'h01);
    pad_ext[1] = 1'b0;
    idle(10);
    bus(1'b0, 3'd5, 32'd0, rd);
    check("edge_ip_fall1", rd, 32'h03);
    bus(1'b1, 3'd5, 32'h01, rd);
    bus(1'b0, 3'd5, 32'd0, rd);
    check("edge_ip_w1c0", rd, 32'h02);
    check("edge_irq_w1c0", 32'(irq), 32'd1);
    bus(1'b1, 3'd5, 32'h02, rd);
    check("edge_irq_w1c1", 32'(irq), 32'd0);
    pad_ext[0] = 1'b0;
    idle(10);

    // Collision: W1C of IP[0] accepted on the edge that sets it; set wins.
    pad_ext[0] = 1'b1;
    idle(6);
    reg_valid = 1'b1; reg_we = 1'b1; reg_addr = 3'd5; reg_wdata = 32'h01;
    @(negedge clk);
    check("coll_ready", 32'(reg_ready), 32'd1);
    check("coll_irq",   32'(irq),       32'd1);
    reg_valid = 1'b0;
    bus(1'b0, 3'd5, 32'd0, rd);
    check("coll_ip", rd, 32'h01);
    bus(1'b1, 3'd5, 32'hFF, rd);
    pad_ext[0] = 1'b0;
    idle(10);

    // Loopback: an output channel is seen on IN 2+DB_CYC cycles after the write.
    bus(1'b1, 3'd1, 32'h00, rd);
    bus(1'b1, 3'd0, 32'h01, rd);
    idle(10);
    bus(1'b0, 3'd2, 32'd0, rd);
    check("loop_in_low", rd, 32'h00);
    bus(1'b1, 3'd1, 32'h01, rd);
    idle(5);
    reg_valid = 1'b1; reg_we = 1'b0; reg_addr = 3'd2;
    @(negedge clk);
    check("loop_in_edge", reg_rdata, 32'h00);
    reg_valid = 1'b0;
    bus(1'b0, 3'd2, 32'd0, rd);
    check("loop_in_high", rd, 32'h01);
    bus(1'b1, 3'd1, 32'h00, rd);
    idle(10);
    bus(1'b0, 3'd2, 32'd0, rd);
    check("loop_in_back", rd, 32'h00);

    // Continuously held valid completes one access every 2 cycles.
    idle(2);
    reg_valid = 1'b1; reg_we = 1'b0; reg_addr = 3'd1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (reg_ready) cnt++;
    end
    reg_valid = 1'b0;
    check("hold_valid_rate", 32'(cnt), 32'd3);

    // Reset during a pending access drops it.
    idle(2);
    reg_valid = 1'b1; reg_we = 1'b1; reg_addr = 3'd0; reg_wdata = 32'hFF; rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_ready", 32'(reg_ready),  32'd0);
    check("rstmid_en",    32'(pad_c2p_en), 32'd0);
    reg_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_noready", 32'(reg_ready), 32'd0);

    // Randomized traffic and pad activity against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(15) == 0) pad_ext[c] = ~pad_ext[c];
      if (reg_valid && reg_ready) begin
        if ($urandom_range(1) == 0) begin
          reg_valid = 1'b0;
        end else begin
          reg_we    = 1'($urandom_range(1));
          reg_addr  = 3'($urandom_range(7));
          reg_wdata = $urandom();
        end
      end else if (!reg_valid && $urandom_range(2) == 0) begin
        reg_valid = 1'b1;
        reg_we    = 1'($urandom_range(1));
        reg_addr  = 3'($urandom_range(7));
        reg_wdata = $urandom();
      end
    end
    reg_valid = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
